// File: rtl/led_program_player.sv
// rtl/led_program_player.sv - plays the selected LED animation, one frame per prescaled tick
module led_program_player #(
    parameter int N_LEDS    = 8,
    parameter int TICK_DIV  = 5_000_000,
    parameter int SNAKE_LEN = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        program_sel,
    input  logic              enable,
    output logic [N_LEDS-1:0] leds,
    output logic              step_tick,
    output logic [3:0]        program_active
);
    localparam int PW = $clog2(TICK_DIV);
    localparam int AW = $clog2(N_LEDS);

    localparam logic [PW-1:0]     PRESC_LAST   = PW'(TICK_DIV - 1);
    localparam logic [AW-1:0]     POS_LAST     = AW'(N_LEDS - 1);
    localparam logic [N_LEDS-1:0] ONES         = '1;
    localparam logic [N_LEDS-1:0] SNAKE_L_INIT = ONES >> (N_LEDS - SNAKE_LEN);
    localparam logic [N_LEDS-1:0] SNAKE_R_INIT = ONES << (N_LEDS - SNAKE_LEN);

    localparam logic [3:0] P_SNAKE_L = 4'd1;
    localparam logic [3:0] P_SNAKE_R = 4'd2;
    localparam logic [3:0] P_BOUNCE  = 4'd3;
    localparam logic [3:0] P_FILL    = 4'd4;
    localparam logic [3:0] P_BLINK   = 4'd5;

    logic [PW-1:0]     presc;
    logic [AW-1:0]     pos;
    logic              dir_up;
    logic [N_LEDS-1:0] step_leds;
    logic [AW-1:0]     step_pos;
    logic              step_dir_up;
    logic              change;
    logic              wrap;

    function automatic logic [N_LEDS-1:0] init_frame(input logic [3:0] p);
        case (p)
            P_SNAKE_L: init_frame = SNAKE_L_INIT;
            P_SNAKE_R: init_frame = SNAKE_R_INIT;
            P_BOUNCE:  init_frame = N_LEDS'(1);
            P_BLINK:   init_frame = ONES;
            default:   init_frame = '0;
        endcase
    endfunction

    assign change = (program_sel != program_active);
    assign wrap   = (presc == PRESC_LAST);

    // Next frame if a step happens this cycle; codes 0 and 6..15 stay dark.
    always_comb begin
        step_leds   = '0;
        step_pos    = pos;
        step_dir_up = dir_up;
        case (program_active)
            P_SNAKE_L: step_leds = {leds[N_LEDS-2:0], leds[N_LEDS-1]};
            P_SNAKE_R: step_leds = {leds[0], leds[N_LEDS-1:1]};
            P_BOUNCE: begin
                if (dir_up) begin
                    if (pos == POS_LAST) begin
                        step_pos    = POS_LAST - 1'b1;
                        step_dir_up = 1'b0;
                    end else begin
                        step_pos = pos + 1'b1;
                    end
                end else begin
                    if (pos == '0) begin
                        step_pos    = AW'(1);
                        step_dir_up = 1'b1;
                    end else begin
                        step_pos = pos - 1'b1;
                    end
                end
                step_leds = N_LEDS'(1) << step_pos;
            end
            P_FILL:  step_leds = (leds == ONES) ? '0 : {leds[N_LEDS-2:0], 1'b1};
            P_BLINK: step_leds = ~leds;
            default: step_leds = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            leds           <= '0;
            step_tick      <= 1'b0;
            program_active <= 4'd0;
            presc          <= '0;
            pos            <= '0;
            dir_up         <= 1'b1;
        end else if (change) begin
            // A new program wins over a coinciding step, even while frozen.
            program_active <= program_sel;
            presc          <= '0;
            pos            <= '0;
            dir_up         <= 1'b1;
            leds           <= init_frame(program_sel);
            step_tick      <= 1'b0;
        end else if (enable && wrap) begin
            presc     <= '0;
            leds      <= step_leds;
            pos       <= step_pos;
            dir_up    <= step_dir_up;
            step_tick <= 1'b1;
        end else begin
            if (enable) begin
                presc <= presc + 1'b1;
            end
            step_tick <= 1'b0;
        end
    end
endmodule

// File: tb/tb_led_program_player.sv
// tb/tb_led_program_player.sv - scoreboard bench for led_program_player
module tb_led_program_player;
    logic       clk;
    logic       rst_n;
    logic [3:0] program_sel;
    logic       enable;
    logic [7:0] leds;
    logic       step_tick;
    logic [3:0] program_active;

    led_program_player #(.N_LEDS(8), .TICK_DIV(4), .SNAKE_LEN(3)) dut (
        .clk(clk), .rst_n(rst_n), .program_sel(program_sel), .enable(enable),
        .leds(leds), .step_tick(step_tick), .program_active(program_active)
    );

    typedef struct {
        logic [7:0] leds;
        logic [3:0] prog;
        int         gap;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   passed = 0;
    int   total = 0;
    int   cyc = 0;
    int   last_cyc = 0;
    int   tick_count = 0;

    logic [7:0] snake_l [8]  = '{8'h0E, 8'h1C, 8'h38, 8'h70, 8'hE0, 8'hC1, 8'h83, 8'h07};
    logic [7:0] bounce [16]  = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40,
                                 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02, 8'h04};
    logic [7:0] fill [10]    = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF,
                                 8'h00, 8'h01};
    logic [7:0] blink [4]    = '{8'h00, 8'hFF, 8'h00, 8'hFF};

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic push(input logic [7:0] l, input logic [3:0] p, input int g);
        exp_t e;
        e.leds = l;
        e.prog = p;
        e.gap  = g;
        sb.push_back(e);
    endtask

    task automatic nstep();
        @(negedge clk);
        #1;
    endtask

    task automatic drain(input int budget, output int n);
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            nstep();
            n++;
        end
        if (sb.size() != 0) begin
            total++;
            $display("FAIL drain_timeout: %0d entries left, expected 0", sb.size());
            sb.delete();
        end
    endtask

    // Every step_tick must match the next queued frame.
    always @(negedge clk) begin
        if (rst_n && step_tick) begin
            tick_count++;
            if (sb.size() == 0) begin
                total++;
                $display("FAIL unexpected_tick: leds %0h with empty scoreboard, expected no tick", leds);
            end else begin
                mon_e = sb.pop_front();
                check("tick_leds", {24'd0, leds}, {24'd0, mon_e.leds});
                check("tick_prog", {28'd0, program_active}, {28'd0, mon_e.prog});
                if (mon_e.gap != 0) check("tick_gap", cyc - last_cyc, mon_e.gap);
            end
            last_cyc = cyc;
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int saved_ticks;
        rst_n       = 1'b0;
        program_sel = 4'd0;
        enable      = 1'b1;
        repeat (3) nstep();
        check("rst_leds", {24'd0, leds}, 32'h0);
        check("rst_prog", {28'd0, program_active}, 32'h0);
        check("rst_tick", {31'd0, step_tick}, 32'h0);

        // Idle still ticks every 4 clocks with all LEDs off.
        rst_n = 1'b1;
        push(8'h00, 4'd0, 0);
        for (int i = 0; i < 4; i++) push(8'h00, 4'd0, 4);
        drain(30, n);

        program_sel = 4'd1;
        nstep();
        check("snake_l_init", {24'd0, leds}, 32'h07);
        check("snake_l_prog", {28'd0, program_active}, 32'h1);
        check("snake_l_notick", {31'd0, step_tick}, 32'h0);
        for (int i = 0; i < 8; i++) push(snake_l[i], 4'd1, (i == 0) ? 5 : 4);
        drain(50, n);

        program_sel = 4'd3;
        nstep();
        check("bounce_init", {24'd0, leds}, 32'h01);
        for (int i = 0; i < 16; i++) push(bounce[i], 4'd3, (i == 0) ? 5 : 4);
        drain(90, n);

        program_sel = 4'd4;
        nstep();
        check("fill_init", {24'd0, leds}, 32'h00);
        for (int i = 0; i < 10; i++) push(fill[i], 4'd4, (i == 0) ? 5 : 4);
        drain(60, n);

        program_sel = 4'd5;
        nstep();
        check("blink_init", {24'd0, leds}, 32'hFF);
        for (int i = 0; i < 4; i++) push(blink[i], 4'd5, (i == 0) ? 5 : 4);
        drain(30, n);

        // Freeze two counts into the period, then resume for the remaining two.
        program_sel = 4'd1;
        nstep();
        check("freeze_init", {24'd0, leds}, 32'h07);
        nstep();
        nstep();
        enable = 1'b0;
        saved_ticks = tick_count;
        repeat (10) nstep();
        check("freeze_leds", {24'd0, leds}, 32'h07);
        check("freeze_noticks", tick_count, saved_ticks);
        enable = 1'b1;
        push(8'h0E, 4'd1, 0);
        drain(20, n);
        check("resume_latency", n, 2);

        push(8'h1C, 4'd1, 4);
        drain(20, n);
        repeat (3) nstep();
        program_sel = 4'd2;
        nstep();
        check("change_on_wrap_tick", {31'd0, step_tick}, 32'h0);
        check("change_on_wrap_leds", {24'd0, leds}, 32'hE0);
        check("change_on_wrap_prog", {28'd0, program_active}, 32'h2);
        push(8'h70, 4'd2, 8);
        drain(20, n);

        rst_n = 1'b0;
        #1;
        check("async_rst_leds", {24'd0, leds}, 32'h0);
        check("async_rst_prog", {28'd0, program_active}, 32'h0);
        nstep();
        nstep();
        rst_n = 1'b1;
        nstep();
        check("reload_leds", {24'd0, leds}, 32'hE0);
        check("reload_prog", {28'd0, program_active}, 32'h2);
        check("sb_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
